// File: rtl/fm_modulation.sv
// FM modulator: phase accumulator driven by -m, quarter-wave sine ROM, signed 8-bit I/Q.
// Four register stages: accumulator, ROM address fold, ROM read, sign/output.
module fm_modulation #(
  parameter int              ACC_W   = 24,
  parameter logic [ACC_W-1:0] FCW    = '0,
  parameter int              K_SHIFT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic signed [15:0] m,
  output logic               out_valid,
  output logic signed [7:0]  I,
  output logic signed [7:0]  Q
);

  // Integer-only sine so the table is built at elaboration:
  // round(127*sin(pi*(2i+1)/1024)) via a Q30 Taylor series.
  function automatic logic [6:0] sin_entry(input int i);
    longint pi_q, x, x2, term, s, r;
    pi_q = 64'sd3373259426;
    x    = (pi_q * longint'(2 * i + 1)) / 64'sd1024;
    x2   = (x * x) >>> 30;
    term = x;
    s    = x;
    for (int k = 1; k <= 8; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      s    = s + term;
    end
    r = (s * 64'sd127 + (64'sd1 <<< 29)) >>> 30;
    return r[6:0];
  endfunction

  function automatic logic [7:0] fold_addr(input logic [9:0] p);
    return p[8] ? ~p[7:0] : p[7:0];
  endfunction

  function automatic logic [7:0] apply_sign(input logic neg, input logic [6:0] l);
    logic [7:0] l8;
    l8 = {1'b0, l};
    return neg ? (~l8 + 8'd1) : l8;
  endfunction

  logic [6:0] rom [256];
  for (genvar g = 0; g < 256; g++) begin : g_rom
    localparam logic [6:0] LV = sin_entry(g);
    assign rom[g] = LV;
  end

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] m_ext;
  logic             v1_q, v2_q, v3_q, out_valid_q;
  logic [9:0]       p_s, p_c;
  logic [7:0]       addr_s_d, addr_c_d, addr_s_q, addr_c_q;
  logic             neg_s2_q, neg_c2_q, neg_s3_q, neg_c3_q;
  logic [6:0]       rom_s_q, rom_c_q;
  logic [7:0]       i_out_q, q_out_q;

  // Size cast of the signed sample sign-extends before the shift.
  assign m_ext = ACC_W'(m);
  assign acc_d = in_valid ? (acc_q + FCW - (m_ext << K_SHIFT)) : acc_q;

  assign p_s      = acc_q[ACC_W-1 -: 10];
  assign p_c      = p_s + 10'd256;
  assign addr_s_d = fold_addr(p_s);
  assign addr_c_d = fold_addr(p_c);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q       <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      addr_s_q    <= '0;
      addr_c_q    <= '0;
      neg_s2_q    <= 1'b0;
      neg_c2_q    <= 1'b0;
      neg_s3_q    <= 1'b0;
      neg_c3_q    <= 1'b0;
      rom_s_q     <= '0;
      rom_c_q     <= '0;
      out_valid_q <= 1'b0;
      i_out_q     <= '0;
      q_out_q     <= '0;
    end else begin
      acc_q       <= acc_d;
      v1_q        <= in_valid;
      addr_s_q    <= addr_s_d;
      addr_c_q    <= addr_c_d;
      neg_s2_q    <= p_s[9];
      neg_c2_q    <= p_c[9];
      v2_q        <= v1_q;
      rom_s_q     <= rom[addr_s_q];
      rom_c_q     <= rom[addr_c_q];
      neg_s3_q    <= neg_s2_q;
      neg_c3_q    <= neg_c2_q;
      v3_q        <= v2_q;
      out_valid_q <= v3_q;
      // I/Q hold their last sample between strobes.
      if (v3_q) begin
        q_out_q <= apply_sign(neg_s3_q, rom_s_q);
        i_out_q <= apply_sign(neg_c3_q, rom_c_q);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign I         = i_out_q;
  assign Q         = q_out_q;

endmodule

// File: doc/fm_modulation.md
# fm_modulation

FM modulator for the I/Q path. It converts a signed 16-bit message sample stream into 8-bit signed I/Q baseband samples using a phase accumulator and a quarter-wave sine ROM. It is the transmit counterpart of `demodulation`, which recovers the message as I·Q_last − Q·I_last. The phase step is taken as −m, so `demodulation` returns +m and not −m.

## Interface
- `ACC_W`, 24: phase accumulator width; requires ACC_W ≥ 17+K_SHIFT and ACC_W ≥ 10.
- `FCW`, 0: carrier frequency control word added every sample; 0 gives a baseband-centred output.
- `K_SHIFT`, 4: deviation scaling; the message is shifted left K_SHIFT bits before it is applied.
- `clk`  in  1  system clock; all registers update on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  qualifies `m`; the accumulator advances only when it is high.
- `m`  in  16  signed message sample.
- `out_valid`  out  1  one-cycle strobe marking new I/Q.
- `I`  out  8  signed cosine output.
- `Q`  out  8  signed sine output.

## Operation
- Stage 1, accumulator:
  - if in_valid: acc ← acc + FCW − (sext(m) <<< K_SHIFT), mod 2^ACC_W.
  - The subtraction is computed in ACC_W bits. m = −32768 is legal and gives +2^(15+K_SHIFT).
  - v1 ← in_valid.
- Stage 2, address:
  - p = acc[ACC_W−1 −: 10]; pc = p + 256 mod 1024 (cosine phase).
  - For each of p and pc: quadrant q = bits[9:8], idx = bits[7:0].
  - Address = idx for q ∈ {0,2}, and 255−idx for q ∈ {1,3}.
  - Negate flag = q[1].
  - Register both addresses and both flags; v2 ← v1.
- Stage 3, ROM:
  - Registered read of two ports from a 256×7-bit ROM.
  - L[i] = round(127·sin(π(2i+1)/1024)). Checkpoints: L[0]=0, L[16]=13, L[239]=126, L[255]=127.
  - Flags pipeline alongside; v3 ← v2.
- Stage 4, output:
  - Q ← flag_s ? −L_s : +L_s; I ← flag_c ? −L_c : +L_c.
  - out_valid ← v3.
  - The range is ±127, so −128 never occurs.
- I and Q load only when v3 = 1 and otherwise hold their last value. out_valid is low whenever v3 = 0.
- Gaps in in_valid freeze the accumulator. Back-to-back in_valid sustains one output per clock, with no stall and no backpressure.
- Reset clears acc, all pipeline registers, valids, I, Q and out_valid to 0, at any time including mid-pipeline. Samples in flight are discarded.

## Timing
- Throughput: 1 sample/clk.
- Latency:
  - in_valid sampled at edge t updates acc at t.
  - I/Q/out_valid for that sample are registered at edge t+3 and visible in the cycle after it (4 register stages).
- out_valid pulse pattern equals the in_valid pattern delayed by 3 edges.
- Reset values: I=0, Q=0, out_valid=0, acc=0.
- The first edge after rst deasserts is a normal capture edge.
- Phase wraps silently at 2^ACC_W. No overflow flag is produced.

## Test plan
- **Reset/idle:** hold rst=0 for 5 clks, then release with in_valid=0 for 10 clks → I=0, Q=0, out_valid=0 throughout.
- **DC phase:** FCW=0, m=0, in_valid=1 for 8 clks → out_valid high from the 4th cycle, I=127, Q=0 each sample.
- **Step sample:** FCW=0, a single in_valid with m=−16384 (step +2^18, p=16) → after 3 edges a single out_valid pulse with I=126, Q=13. The next 10 idle cycles hold I=126, Q=13 with out_valid=0.
- **Quadrant/wrap:** FCW=0, m=−32768 streamed (p advances by 32 per sample):
  - sample 8: p=256, I=0, Q=127.
  - sample 16: p=512, I=−127, Q=0.
  - sample 24: p=768, I=0, Q=−127.
  - sample 32: wraps to p=0, I=127, Q=0.
- **Loopback:** random m ∈ [−2048, 2047] streamed into fm_modulation feeding `demodulation` → the demodulated output has the same sign as m and tracks it monotonically; no sign inversion on any sample.
- **Reset mid-stream:**
  - Assert rst for 1 clk while 3 samples are in flight → I, Q and out_valid go to 0 immediately (asynchronously); none of the in-flight samples ever produces an out_valid.
  - Next in_valid with m=0 and FCW=0 → I=127, Q=0.
